vga_timing: RTL
===============

# vga_timing

VGA raster timing generator, the counterpart to the VGA register block. It consumes the `vga_en` control bit from the register block. It produces the `hblank`/`vblank` status that the register block reads back, plus sync, data-enable and pixel coordinates for the pixel pipeline and DAC pins. Default geometry is 640x480@60 with a 25 MHz pixel rate, taken as a clock enable from the 50 MHz system clock.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `CNT_W`, 10, width of `hcnt`/`vcnt`; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `pix_en`  in  1  pixel clock enable, one `clk` pulse per pixel
- `vga_en`  in  1  module enable from the register block
- `hcnt`  out  CNT_W  current pixel column, 0..H_TOTAL-1
- `vcnt`  out  CNT_W  current line, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `hblank`  out  1  high when `hcnt >= H_ACTIVE`, or when idle
- `vblank`  out  1  high when `vcnt >= V_ACTIVE`, or when idle
- `de`  out  1  display enable = !hblank & !vblank
- `frame_start`  out  1  one-`clk` pulse when entering (0,0)
- `frame_cnt`  out  16  frames started since enable (only with `VGA_FRAME_CNT_EN`)

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Idle state (reset, or `vga_en` low):
  - hcnt=0, vcnt=0
  - hsync=1, vsync=1
  - hblank=1, vblank=1, de=0
  - frame_start=0
- Start: in any `clk` where `vga_en` is high and the block is idle, the registers load state (0,0). That gives hblank=0, vblank=0, de=1, frame_start=1. The `pix_en` value is ignored in that cycle.
- Running, on each `clk` with `pix_en` high:
  - hcnt increments.
  - When hcnt = H_TOTAL-1, hcnt wraps to 0 and vcnt increments.
  - When vcnt = V_TOTAL-1 as well, vcnt wraps to 0 and frame_start pulses.
- Running, `pix_en` low: all registered outputs hold, except frame_start, which is 0.
- Decode, applied to the new counter values:
  - hsync=0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync=0 iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
  - hblank and vblank follow the thresholds listed under Interface.
- `vga_en` falling mid-frame: on the next `clk` edge the block enters idle, regardless of `pix_en`. Re-enabling always restarts at (0,0).
- Reset takes priority over `vga_en` and `pix_en`.

## Timing
- Every output is a flop. hsync, vsync, hblank, vblank, de and frame_start are decoded from the next-state counters. They therefore change on the same edge as `hcnt`/`vcnt`, with zero skew relative to the coordinates.
- Latency from `vga_en` sampled high to `de`=1 is one `clk`.
- Latency from `vga_en` sampled low to idle outputs is one `clk`.
- A full frame spans H_TOTAL*V_TOTAL `pix_en` pulses (420000).
- frame_start is exactly one `clk` wide, even when `pix_en` is held high continuously.

## Configuration
- `VGA_FRAME_CNT_EN` defined: `frame_cnt` exists as a 16-bit register.
  - Reset value 0.
  - Cleared on entering idle.
  - Increments in every cycle where frame_start=1, including the start cycle, so it reads 1 after enable.
  - Wraps 0xFFFF -> 0x0000.
- `VGA_FRAME_CNT_EN` undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset with `vga_en`=1 and `pix_en` toggling -> during and one cycle after `rst`: hcnt=vcnt=0, hsync=vsync=1, hblank=vblank=1, de=0.
- Enable, then `pix_en` every 2nd clk:
  - hsync goes 0 when hcnt=656 and returns 1 when hcnt=752.
  - hblank goes 1 when hcnt=640.
  - hcnt wraps 799->0 and vcnt increments 0->1 on the same edge.
- Run one full frame:
  - vblank=1 for vcnt 480..524.
  - vsync=0 for vcnt 490..491.
  - frame_start pulses exactly twice: at enable, and again after 420000 `pix_en` pulses.
- Deassert `vga_en` at hcnt=300, vcnt=200 -> next clk idle. Reassert -> next clk hcnt=0, vcnt=0, de=1, frame_start=1.
- Hold `pix_en`=0 for 50 clks at hcnt=655 -> all outputs hold and frame_start stays 0. The next `pix_en` gives hcnt=656, hsync=0.
- With `VGA_FRAME_CNT_EN` and a reduced geometry (H_ACTIVE=4, V_ACTIVE=2, all porches and syncs =1):
  - frame_cnt reads 3 after two frame wraps.
  - Preloading frame_cnt to 0xFFFF by force, the next frame_start gives 0x0000.

Source files
------------

// File: rtl/vga_timing.sv
// ============================================================================
// Module      : vga_timing
// Description : VGA raster timing generator. Optional frame counter is built
//               when VGA_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pix_en,
    input  logic             vga_en,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank,
    output logic             de,
    output logic             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] c_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic [CNT_W-1:0] w_hcnt_nxt;
    logic [CNT_W-1:0] w_vcnt_nxt;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_hblank;
    logic             r_vblank;
    logic             r_de;
    logic             r_frame_start;
    logic             w_run_nxt;
    logic             w_fs_nxt;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_hblank_nxt;
    logic             w_vblank_nxt;
    logic             w_de_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hcnt        <= '0;
            r_vcnt        <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_hblank      <= 1'b1;
            r_vblank      <= 1'b1;
            r_de          <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hcnt        <= w_hcnt_nxt;
            r_vcnt        <= w_vcnt_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_hblank      <= w_hblank_nxt;
            r_vblank      <= w_vblank_nxt;
            r_de          <= w_de_nxt;
            r_frame_start <= w_fs_nxt;
        end
    end

    // Status flags are decoded from the next-state counters so they change
    // on the same edge as the coordinates they describe.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_vcnt_nxt  = r_vcnt;
        w_fs_nxt    = 1'b0;

        if (!vga_en) begin
            w_state_nxt = ST_IDLE;
            w_hcnt_nxt  = '0;
            w_vcnt_nxt  = '0;
        end else if (r_state == ST_IDLE) begin
            w_state_nxt = ST_RUN;
            w_hcnt_nxt  = '0;
            w_vcnt_nxt  = '0;
            w_fs_nxt    = 1'b1;
        end else if (pix_en) begin
            if (r_hcnt == c_H_LAST) begin
                w_hcnt_nxt = '0;
                if (r_vcnt == c_V_LAST) begin
                    w_vcnt_nxt = '0;
                    w_fs_nxt   = 1'b1;
                end else begin
                    w_vcnt_nxt = r_vcnt + 1'b1;
                end
            end else begin
                w_hcnt_nxt = r_hcnt + 1'b1;
            end
        end

        w_run_nxt    = (w_state_nxt == ST_RUN);
        w_hsync_nxt  = !(w_run_nxt && (w_hcnt_nxt >= c_HS_BEG) && (w_hcnt_nxt < c_HS_END));
        w_vsync_nxt  = !(w_run_nxt && (w_vcnt_nxt >= c_VS_BEG) && (w_vcnt_nxt < c_VS_END));
        w_hblank_nxt = !w_run_nxt || (w_hcnt_nxt >= c_H_ACT);
        w_vblank_nxt = !w_run_nxt || (w_vcnt_nxt >= c_V_ACT);
        w_de_nxt     = !w_hblank_nxt && !w_vblank_nxt;
    end

    assign hcnt        = r_hcnt;
    assign vcnt        = r_vcnt;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblank      = r_hblank;
    assign vblank      = r_vblank;
    assign de          = r_de;
    assign frame_start = r_frame_start;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Counts the start cycle too, so the first frame after enable reads 1.
    always_ff @(posedge clk) begin
        if (rst || (w_state_nxt == ST_IDLE)) begin
            r_frame_cnt <= '0;
        end else if (w_fs_nxt) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

endmodule

`default_nettype wire
